microwave_timer_ctrl: RTL

Time-setting and countdown controller for the microwave datapath, sitting between the microwave control FSM and the FND display/motor/buzzer drivers. It decodes the FSM's `sel`/`run`/`toggle` outputs into edits of a minute:second register pair, counts that register down at 1 Hz while running, and returns a one-cycle `finish` pulse to the FSM. It also drives the motor enable and sequences a fixed beep pattern in the FINISH state.

---
 rtl/microwave_timer_ctrl_if.sv | 24 ++
 rtl/microwave_timer_ctrl.sv | 110 +++++++++++
 2 files changed

// File: rtl/microwave_timer_ctrl_if.sv
// Control-FSM side bundle for the microwave timer: edit/run/finish controls plus
// the time and actuator outputs feeding the display, motor and buzzer drivers.
interface microwave_timer_ctrl_if;
  logic [1:0] sel;
  logic       run;
  logic       toggle;
  logic       btn_up;
  logic       btn_down;
  logic [6:0] min;
  logic [5:0] sec;
  logic       finish;
  logic       motor_en;
  logic       buzzer;

  modport master (
    output sel, run, toggle, btn_up, btn_down,
    input  min, sec, finish, motor_en, buzzer
  );

  modport slave (
    input  sel, run, toggle, btn_up, btn_down,
    output min, sec, finish, motor_en, buzzer
  );
endinterface

// File: rtl/microwave_timer_ctrl.sv
// Minute:second edit and 1 Hz countdown for the microwave, with finish pulse,
// motor enable and a fixed beep sequence while the FSM sits in FINISH.
module microwave_timer_ctrl #(
  parameter int TICK_DIV   = 100_000_000,
  parameter int BEEP_HALF  = 25_000_000,
  parameter int BEEP_COUNT = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  microwave_timer_ctrl_if.slave  bus
);

  localparam int PW  = $clog2(TICK_DIV);
  localparam int HW  = $clog2(BEEP_HALF + 1);
  localparam int NHP = 2 * BEEP_COUNT;
  localparam int CW  = $clog2(NHP + 1);

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [HW-1:0] HALF_LAST  = HW'(BEEP_HALF - 1);
  localparam logic [CW-1:0] HP_END     = CW'(NHP);

  logic [6:0]    r_min;
  logic [5:0]    r_sec;
  logic [PW-1:0] r_presc;
  logic          r_finish;
  logic          r_fin_sent;
  logic          r_motor_en;
  logic          r_buzzer;
  logic [HW-1:0] r_half;
  logic [CW-1:0] r_hp;

  logic w_tick;
  logic w_zero;
  logic w_edit;
  logic w_beep;

  assign w_tick = bus.run && (r_presc == PRESC_LAST);
  assign w_zero = (r_min == 7'd0) && (r_sec == 6'd0);
  assign w_edit = !bus.run && !bus.toggle && (bus.btn_up ^ bus.btn_down);
  // Buzzer only sequences in a legal FINISH; a running countdown overrides it.
  assign w_beep = bus.toggle && !bus.run;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_min <= 7'd0;
      r_sec <= 6'd0;
    end else if (w_tick) begin
      if (r_sec != 6'd0) begin
        r_sec <= r_sec - 6'd1;
      end else if (r_min != 7'd0) begin
        r_sec <= 6'd59;
        r_min <= r_min - 7'd1;
      end
    end else if (w_edit) begin
      if (bus.sel == 2'b01) begin
        if (bus.btn_up) r_sec <= (r_sec == 6'd59) ? 6'd0  : r_sec + 6'd1;
        else            r_sec <= (r_sec == 6'd0)  ? 6'd59 : r_sec - 6'd1;
      end else if (bus.sel == 2'b10) begin
        if (bus.btn_up) r_min <= (r_min == 7'd99) ? 7'd0  : r_min + 7'd1;
        else            r_min <= (r_min == 7'd0)  ? 7'd99 : r_min - 7'd1;
      end
    end
  end

  // finish fires once per run-high period, as soon as the time reads 00:00.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_presc    <= '0;
      r_finish   <= 1'b0;
      r_fin_sent <= 1'b0;
      r_motor_en <= 1'b0;
    end else begin
      if (!bus.run || w_tick) r_presc <= '0;
      else                    r_presc <= r_presc + 1'b1;
      r_finish   <= bus.run && w_zero && !r_fin_sent;
      r_fin_sent <= bus.run && (r_fin_sent || w_zero);
      r_motor_en <= bus.run && !w_zero;
    end
  end

  // r_hp counts completed half-periods; even indices are the high halves.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_half   <= '0;
      r_hp     <= '0;
      r_buzzer <= 1'b0;
    end else if (!w_beep) begin
      r_half   <= '0;
      r_hp     <= '0;
      r_buzzer <= 1'b0;
    end else if (r_hp < HP_END) begin
      r_buzzer <= ~r_hp[0];
      if (r_half == HALF_LAST) begin
        r_half <= '0;
        r_hp   <= r_hp + 1'b1;
      end else begin
        r_half <= r_half + 1'b1;
      end
    end else begin
      r_buzzer <= 1'b0;
    end
  end

  assign bus.min      = r_min;
  assign bus.sec      = r_sec;
  assign bus.finish   = r_finish;
  assign bus.motor_en = r_motor_en;
  assign bus.buzzer   = r_buzzer;

endmodule
